// File: rtl/alu_mc_pkg.sv
// alu_mc shared types: opcode enum, FSM state enum and the multi-cycle
// opcode classifier used by the top level.
package alu_mc_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_NAND = 5'd2,
    OP_NOR  = 5'd3,
    OP_XNOR = 5'd4,
    OP_AND  = 5'd5,
    OP_OR   = 5'd6,
    OP_XOR  = 5'd7,
    OP_SLL  = 5'd8,
    OP_SRL  = 5'd9,
    OP_SLA  = 5'd10,
    OP_SRA  = 5'd11,
    OP_LUI  = 5'd12,
    OP_LLI  = 5'd13,
    OP_CMP  = 5'd14,
    OP_MUL  = 5'd15,
    OP_MULH = 5'd16,
    OP_DIV  = 5'd17,
    OP_REM  = 5'd18
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Opcodes served by the iterative multiply/divide engine.
  function automatic logic is_multicycle(input alu_op_t op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_mc_muldiv.sv
// alu_mc_muldiv: radix-2 signed multiply / divide engine working on operand
// magnitudes. Loads on start, runs exactly DATA_WIDTH iterations, and presents
// the sign-corrected results combinationally in the cycle 'done' is high so
// the caller can register them on the same edge as the last iteration.
module alu_mc_muldiv
  import alu_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  alu_op_t                 op,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic [DATA_WIDTH-1:0]   quotient,
  output logic [DATA_WIDTH-1:0]   remainder,
  output logic                    dz,
  output logic                    ovf
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  logic          run, is_div, neg_p, neg_q, neg_r, dz_q, ovf_q;
  logic [CW-1:0] cnt;
  // hi: partial product high half / partial remainder
  // lo: multiplier bits shifting out / dividend bits shifting out, quotient in
  logic [W-1:0]  hi, lo, m, a_q;
  logic [W-1:0]  hi_n, lo_n, ma, mb;
  logic [W:0]    sum, trial;
  logic          div_in;

  assign ma     = a[W-1] ? -a : a;
  assign mb     = b[W-1] ? -b : b;
  assign div_in = (op == OP_DIV) || (op == OP_REM);

  // One iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    trial = {hi, lo[W-1]} - {1'b0, m};
    if (is_div) begin
      if (!trial[W]) begin
        hi_n = trial[W-1:0];
        lo_n = {lo[W-2:0], 1'b1};
      end else begin
        hi_n = {hi[W-2:0], lo[W-1]};
        lo_n = {lo[W-2:0], 1'b0};
      end
    end else begin
      hi_n = sum[W:1];
      lo_n = {sum[0], lo[W-1:1]};
    end
  end

  assign done      = run && (cnt == CW'(W-1));
  assign product   = neg_p ? -{hi_n, lo_n} : {hi_n, lo_n};
  // Divide by zero overrides the iteration: all-ones quotient, remainder = a.
  assign quotient  = dz_q ? '1  : (neg_q ? -lo_n : lo_n);
  assign remainder = dz_q ? a_q : (neg_r ? -hi_n : hi_n);
  assign dz        = dz_q & is_div;
  assign ovf       = ovf_q & is_div;

  // Load operands on start, then iterate until the count expires.
  always_ff @(posedge clk) begin
    if (reset) begin
      run    <= 1'b0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_p  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz_q   <= 1'b0;
      ovf_q  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      m      <= '0;
      a_q    <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      is_div <= div_in;
      neg_p  <= a[W-1] ^ b[W-1];
      neg_q  <= a[W-1] ^ b[W-1];
      neg_r  <= a[W-1];
      dz_q   <= (b == '0);
      ovf_q  <= (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);
      a_q    <= a;
      hi     <= '0;
      lo     <= div_in ? ma : mb;
      m      <= div_in ? mb : ma;
    end else if (run) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: handshaked ALU. Single-cycle ops register their result at accept
// (latency 1); MUL/MULH/DIV/REM run on an iterative engine (latency
// DATA_WIDTH+1). Define ALU_MC_MULDIV_EN to build the engine; without it the
// multiply/divide opcodes are treated as illegal (result 1, latency 1).
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [4:0]            op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  neg,
  output logic                  grt,
  output logic                  eq,
  output logic                  ovf,
  output logic                  dz
);

  localparam int W = DATA_WIDTH;

  state_t               state, state_nx;
  alu_op_t              op_in;
  logic                 accept, mc_in, md_done;
  logic [W-1:0]         sum, diff, alu_res;
  logic [SHAMT_W-1:0]   shamt;
  logic                 alu_ovf;

  assign op_in  = alu_op_t'(op);
  assign accept = in_valid & in_ready;

`ifdef ALU_MC_MULDIV_EN
  alu_op_t              op_q;
  logic [2*W-1:0]       md_prod;
  logic [W-1:0]         md_quot, md_rem, md_res;
  logic                 md_dz, md_ovf;

  assign mc_in = is_multicycle(op_in);

  alu_mc_muldiv #(.DATA_WIDTH(W)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start     (accept & mc_in),
    .op        (op_in),
    .a         (a),
    .b         (b),
    .done      (md_done),
    .product   (md_prod),
    .quotient  (md_quot),
    .remainder (md_rem),
    .dz        (md_dz),
    .ovf       (md_ovf)
  );

  // Pick the engine output that matches the captured opcode.
  always_comb begin
    case (op_q)
      OP_MUL:  md_res = md_prod[W-1:0];
      OP_MULH: md_res = md_prod[2*W-1:W];
      OP_DIV:  md_res = md_quot;
      default: md_res = md_rem;
    endcase
  end
`else
  assign mc_in   = 1'b0;
  assign md_done = 1'b0;
`endif

  // Single-cycle datapath; anything unnamed (and mul/div here) yields 1.
  always_comb begin
    sum     = a + b;
    diff    = a - b;
    shamt   = b[SHAMT_W-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_in)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      OP_NAND:        alu_res = ~(a & b);
      OP_NOR:         alu_res = ~(a | b);
      OP_XNOR:        alu_res = ~(a ^ b);
      OP_AND:         alu_res = a & b;
      OP_OR:          alu_res = a | b;
      OP_XOR:         alu_res = a ^ b;
      OP_SLL, OP_SLA: alu_res = a << shamt;
      OP_SRL:         alu_res = a >> shamt;
      OP_SRA:         alu_res = $signed(a) >>> shamt;
      OP_LUI:         alu_res = W'(b[7:0]) << (W - 8);
      OP_LLI:         alu_res = W'(b[7:0]);
      OP_CMP:         alu_res = '0;
      default:        alu_res = W'(1);
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state: DONE with out_ready may chain straight into the next op.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = mc_in ? S_BUSY : S_DONE;
      S_BUSY: if (md_done) state_nx = S_DONE;
      S_DONE: if (out_ready) state_nx = accept ? (mc_in ? S_BUSY : S_DONE) : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Handshake outputs.
  always_comb begin
    in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    out_valid = (state == S_DONE);
  end

  // Result/flag registers: loaded at accept (single-cycle) or at engine done.
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      grt    <= 1'b0;
      eq     <= 1'b0;
      ovf    <= 1'b0;
      dz     <= 1'b0;
`ifdef ALU_MC_MULDIV_EN
      op_q   <= OP_ADD;
`endif
    end else if (accept) begin
      grt <= $signed(a) > $signed(b);
      eq  <= (a == b);
`ifdef ALU_MC_MULDIV_EN
      op_q <= op_in;
`endif
      if (!mc_in) begin
        result <= alu_res;
        zero   <= (alu_res == '0);
        neg    <= alu_res[W-1];
        ovf    <= alu_ovf;
        dz     <= 1'b0;
      end
`ifdef ALU_MC_MULDIV_EN
    end else if ((state == S_BUSY) && md_done) begin
      result <= md_res;
      zero   <= (md_res == '0);
      neg    <= md_res[W-1];
      ovf    <= md_ovf && (op_q == OP_DIV);
      dz     <= md_dz;
`endif
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (DATA_WIDTH=16). Stimulus pushes the expected
// response on accept; a monitor pops and compares on every output handshake.
// Mul/div expectations follow ALU_MC_MULDIV_EN (illegal-op result otherwise).
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0, reset = 1'b1;
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [W-1:0] a = '0, b = '0, result;
  logic [4:0]   op = '0;
  logic         zero, neg, grt, eq, ovf, dz;

  alu_mc #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .neg(neg), .grt(grt), .eq(eq),
    .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // fl = {zero, neg, grt, eq, ovf, dz}
  typedef struct {
    string        nm;
    logic [W-1:0] res;
    logic [5:0]   fl;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input bit ok, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Monitor: one comparison per output handshake.
  initial forever begin
    @(negedge clk);
    #1;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 1'b0, {result, 10'b0, zero, neg, grt, eq, ovf, dz}, 32'h0);
      end else begin
        me = sb.pop_front();
        chk(me.nm, (result == me.res) && ({zero, neg, grt, eq, ovf, dz} == me.fl),
            {result, 10'b0, zero, neg, grt, eq, ovf, dz}, {me.res, 10'b0, me.fl});
        if (me.lat > 0)
          chk({me.nm, "_latency"}, (cyc - me.acc) == me.lat, cyc - me.acc, me.lat);
      end
    end
  end

  // Offer one op; lat < 0 means no response is expected (aborted op).
  task automatic issue(input string nm, input logic [4:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] res, input logic [5:0] fl, input int lat, input bit ordy,
                       output int waits);
    exp_t e;
    @(negedge clk);
    op = o; a = ia; b = ib; in_valid = 1'b1; out_ready = ordy;
    waits = 0;
    #1;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!in_ready) begin
      chk({nm, "_accept_timeout"}, 1'b0, waits, 0);
      in_valid = 1'b0;
      return;
    end
    if (lat >= 0) begin
      e.nm = nm; e.res = res; e.fl = fl; e.acc = cyc; e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic iss(input string nm, input logic [4:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                     input logic [W-1:0] res, input logic [5:0] fl);
    int w;
    issue(nm, o, ia, ib, res, fl, 1, 1'b1, w);
  endtask

  task automatic md(input string nm, input logic [4:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                    input logic [W-1:0] res, input logic [5:0] fl);
    int w;
`ifdef ALU_MC_MULDIV_EN
    issue(nm, o, ia, ib, res, fl, W + 1, 1'b1, w);
`else
    issue(nm, o, ia, ib, 16'h0001, {2'b00, fl[3:2], 2'b00}, 1, 1'b1, w);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
    end
  endtask

  initial begin
    int  w, t;
    bit  ok;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    chk("reset_state", !out_valid && in_ready && result == '0 && {zero, neg, grt, eq, ovf, dz} == 6'b0,
        {out_valid, in_ready, result, zero, neg, grt, eq, ovf, dz}, 32'h0001_0000 >> 0 & 32'h0);

    // Single-cycle ops, back-to-back with out_ready held high.
    iss("add_ovf",  OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 6'b011010);
    iss("sub_eq",   OP_SUB,  16'h0005, 16'h0005, 16'h0000, 6'b100100);
    iss("cmp",      OP_CMP,  16'hFFFD, 16'h0002, 16'h0000, 6'b100000);
    iss("lui",      OP_LUI,  16'h0000, 16'h12AB, 16'hAB00, 6'b010000);
    iss("nand",     OP_NAND, 16'hF0F0, 16'hFF00, 16'h0FFF, 6'b000000);
    iss("nor",      OP_NOR,  16'hF0F0, 16'h0F00, 16'h000F, 6'b000000);
    iss("xnor",     OP_XNOR, 16'hAAAA, 16'h5555, 16'h0000, 6'b100000);
    iss("and",      OP_AND,  16'h0FF0, 16'h00FF, 16'h00F0, 6'b001000);
    iss("or",       OP_OR,   16'h0F00, 16'h00F0, 16'h0FF0, 6'b001000);
    iss("xor",      OP_XOR,  16'h1234, 16'h1234, 16'h0000, 6'b100100);
    iss("sll_mask", OP_SLL,  16'h0001, 16'h0014, 16'h0010, 6'b000000);
    iss("sla",      OP_SLA,  16'h8001, 16'h0001, 16'h0002, 6'b000000);
    iss("srl",      OP_SRL,  16'h8000, 16'h0003, 16'h1000, 6'b000000);
    iss("lli",      OP_LLI,  16'h0000, 16'h12AB, 16'h00AB, 6'b000000);
    iss("illegal",  5'd25,   16'h0003, 16'h0003, 16'h0001, 6'b000100);
    iss("sub_ovf",  OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 6'b000010);

    // Multiply / divide.
    md("mul", OP_MUL, 16'hFED4, 16'h0007, 16'hF7CC, 6'b010000);
`ifdef ALU_MC_MULDIV_EN
    ok = 1'b1;
    repeat (W) begin
      @(negedge clk); #1;
      if (in_ready || out_valid) ok = 1'b0;
    end
    chk("busy_not_ready", ok, {in_ready, out_valid}, 0);
`endif
    md("mulh",    OP_MULH, 16'hFED4, 16'h0007, 16'hFFFF, 6'b010000);
    md("div",     OP_DIV,  16'hFFF9, 16'h0002, 16'hFFFD, 6'b010000);
    md("rem",     OP_REM,  16'hFFF9, 16'h0002, 16'hFFFF, 6'b010000);
    md("div_ovf", OP_DIV,  16'h8000, 16'hFFFF, 16'h8000, 6'b010010);
    md("div_z",   OP_DIV,  16'h0005, 16'h0000, 16'hFFFF, 6'b011001);
    md("rem_z",   OP_REM,  16'h0005, 16'h0000, 16'h0005, 6'b001001);

    // Backpressure: result must hold for 5 cycles, then a new op rides the release.
    idle(3);
    issue("sra_bp", OP_SRA, 16'h8000, 16'h0003, 16'hF000, 6'b010000, 0, 1'b0, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk($sformatf("bp_hold_%0d", i), out_valid && !in_ready && result == 16'hF000,
          {out_valid, in_ready, result}, {1'b1, 1'b0, 16'hF000});
    end
    issue("add_after_bp", OP_ADD, 16'h1234, 16'h0001, 16'h1235, 6'b001000, 1, 1'b1, w);
    chk("bp_accept_same_cycle", w == 0, w, 0);

    // Reset in the middle of a divide aborts it without output.
    idle(3);
    issue("div_abort", OP_DIV, 16'd100, 16'd7, 16'h0000, 6'b000000, -1, 1'b0, w);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    chk("reset_abort", !out_valid && in_ready && result == '0 && {zero, neg, grt, eq, ovf, dz} == 6'b0,
        {out_valid, in_ready, result, zero, neg, grt, eq, ovf, dz}, {1'b0, 1'b1, 22'h0});
    out_ready = 1'b1;
    iss("add_post_rst", OP_ADD, 16'h0002, 16'h0003, 16'h0005, 6'b000000);

    t = 0;
    while (sb.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drain", sb.size() == 0, sb.size(), 0);
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
